// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg
// Shared definitions for the SPARC V8 memory stage:
//   - op3 opcode constants for the supported loads/stores
//   - access size encoding (SZ_BYTE / SZ_HALF / SZ_WORD)
//   - controller state enum (IDLE / ACCESS / DONE)
//   - decode_op(): op3 -> {size, signed, store, valid}
//   - last_index(): index of the final byte for a given size
package sparc_mem_pkg;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    size_t size;
    logic  is_signed;
    logic  is_store;
    logic  valid;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [5:0] op);
    op_dec_t d;
    d = '{size: SZ_BYTE, is_signed: 1'b0, is_store: 1'b0, valid: 1'b0};
    case (op)
      OP_LD:   d = '{size: SZ_WORD, is_signed: 1'b0, is_store: 1'b0, valid: 1'b1};
      OP_LDUB: d = '{size: SZ_BYTE, is_signed: 1'b0, is_store: 1'b0, valid: 1'b1};
      OP_LDUH: d = '{size: SZ_HALF, is_signed: 1'b0, is_store: 1'b0, valid: 1'b1};
      OP_ST:   d = '{size: SZ_WORD, is_signed: 1'b0, is_store: 1'b1, valid: 1'b1};
      OP_STB:  d = '{size: SZ_BYTE, is_signed: 1'b0, is_store: 1'b1, valid: 1'b1};
      OP_STH:  d = '{size: SZ_HALF, is_signed: 1'b0, is_store: 1'b1, valid: 1'b1};
      OP_LDSB: d = '{size: SZ_BYTE, is_signed: 1'b1, is_store: 1'b0, valid: 1'b1};
      OP_LDSH: d = '{size: SZ_HALF, is_signed: 1'b1, is_store: 1'b0, valid: 1'b1};
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] last_index(input size_t s);
    case (s)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/sparc_byte_ram.sv
// sparc_byte_ram
// DEPTH x 8 byte-wide RAM, synchronous write, combinational read.
// Contents are never reset.
//   Clk  : clock, write on rising edge
//   we   : write enable
//   addr : byte address
//   din  : write data
//   dout : read data at addr (combinational)
module sparc_byte_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] Mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) Mem[addr] <= din;
  end

  assign dout = Mem[addr];

endmodule

// File: rtl/ram_access_controller.sv
// ram_access_controller
// Memory stage behind MAR/MDR. Executes SPARC V8 big-endian byte, halfword
// and word loads/stores one byte at a time against sparc_byte_ram, with
// WAIT_STATES idle cycles before every byte, alignment checking and load
// sign/zero extension.
//   Clk                  : clock
//   Clr                  : asynchronous active-low reset
//   RAM_enable           : request
//   RAM_OpCode           : SPARC op3
//   MAR_in               : byte address (bits above log2(DEPTH) ignored)
//   MDR_in               : store data, right-justified for STB/STH
//   RAM_DataOut          : extended load result
//   MFC                  : memory function complete
//   mem_addr_not_aligned : alignment fault, meaningful while MFC=1
//   busy                 : high while bytes are being transferred
//
// Handshake (four-phase): the requester raises RAM_enable and holds it until
// it sees MFC=1, then drops it. MFC stays high while RAM_enable stays high and
// falls on the first edge that samples RAM_enable=0. Request inputs are only
// sampled in IDLE, so a new request needs a full drop/raise of RAM_enable.
// If RAM_enable is dropped early, the access still completes and MFC pulses
// for a single cycle.
module ram_access_controller
  import sparc_mem_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] MAR_in,
  input  logic [31:0] MDR_in,
  output logic [31:0] RAM_DataOut,
  output logic        MFC,
  output logic        mem_addr_not_aligned,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  size_t         size_q;
  logic          signed_q;
  logic          store_q;
  logic          valid_q;
  logic          misalign_q;
  logic [1:0]    k;
  logic [3:0]    wcnt;
  logic [31:0]   acc;

  op_dec_t       dec;
  logic          misalign;
  logic          xfer;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic [31:0]   load_result;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^MAR_in[31:AW];

  always_comb dec = decode_op(RAM_OpCode);

  always_comb begin
    misalign = 1'b0;
    case (dec.size)
      SZ_HALF: misalign = MAR_in[0];
      SZ_WORD: misalign = |MAR_in[1:0];
      default: misalign = 1'b0;
    endcase
  end

  // A byte moves on the cycle the wait counter has reached zero.
  assign xfer     = (state == ACCESS) && (wcnt == 4'd0);
  assign ram_we   = xfer && store_q;
  assign ram_addr = addr_q + AW'(k);

  // Big-endian: byte k=0 is the most significant byte of the operand.
  always_comb begin
    ram_din = data_q[7:0];
    case (size_q)
      SZ_HALF: ram_din = (k == 2'd0) ? data_q[15:8] : data_q[7:0];
      SZ_WORD: begin
        case (k)
          2'd0:    ram_din = data_q[31:24];
          2'd1:    ram_din = data_q[23:16];
          2'd2:    ram_din = data_q[15:8];
          default: ram_din = data_q[7:0];
        endcase
      end
      default: ram_din = data_q[7:0];
    endcase
  end

  always_comb begin
    load_result = acc;
    case (size_q)
      SZ_BYTE: load_result = {{24{signed_q & acc[7]}}, acc[7:0]};
      SZ_HALF: load_result = {{16{signed_q & acc[15]}}, acc[15:0]};
      default: load_result = acc;
    endcase
  end

  sparc_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) ram (
    .Clk  (Clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state                <= IDLE;
      addr_q               <= '0;
      data_q               <= '0;
      size_q               <= SZ_BYTE;
      signed_q             <= 1'b0;
      store_q              <= 1'b0;
      valid_q              <= 1'b0;
      misalign_q           <= 1'b0;
      k                    <= 2'd0;
      wcnt                 <= 4'd0;
      acc                  <= '0;
      RAM_DataOut          <= '0;
      MFC                  <= 1'b0;
      mem_addr_not_aligned <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (RAM_enable) begin
            addr_q     <= MAR_in[AW-1:0];
            data_q     <= MDR_in;
            size_q     <= dec.size;
            signed_q   <= dec.is_signed;
            store_q    <= dec.is_store;
            valid_q    <= dec.valid;
            misalign_q <= dec.valid && misalign;
            acc        <= '0;
            k          <= 2'd0;
            wcnt       <= 4'(WAIT_STATES);
            if (dec.valid && !misalign) begin
              state <= ACCESS;
              busy  <= 1'b1;
            end else begin
              // Faulting or undefined requests skip the array entirely.
              state <= DONE;
            end
          end
        end
        ACCESS: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            if (!store_q) acc <= {acc[23:0], ram_dout};
            if (k == last_index(size_q)) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              k    <= k + 2'd1;
              wcnt <= 4'(WAIT_STATES);
            end
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; later cycles wait for
          // the requester to drop RAM_enable.
          if (!MFC) begin
            MFC                  <= 1'b1;
            mem_addr_not_aligned <= misalign_q;
            if (!valid_q) RAM_DataOut <= '0;
            else if (!store_q && !misalign_q) RAM_DataOut <= load_result;
          end else if (!RAM_enable) begin
            state                <= IDLE;
            MFC                  <= 1'b0;
            mem_addr_not_aligned <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_controller.sv
// Directed bench for ram_access_controller (DEPTH=512, WAIT_STATES=1).
module tb_ram_access_controller;
  import sparc_mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        RAM_enable;
  logic [5:0]  RAM_OpCode;
  logic [31:0] MAR_in;
  logic [31:0] MDR_in;
  logic [31:0] RAM_DataOut;
  logic        MFC;
  logic        mem_addr_not_aligned;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int lat;

  // clock / reset block
  always #5 Clk = ~Clk;

  ram_access_controller #(
    .DEPTH       (512),
    .WAIT_STATES (1)
  ) dut (
    .Clk                  (Clk),
    .Clr                  (Clr),
    .RAM_enable           (RAM_enable),
    .RAM_OpCode           (RAM_OpCode),
    .MAR_in               (MAR_in),
    .MDR_in               (MDR_in),
    .RAM_DataOut          (RAM_DataOut),
    .MFC                  (MFC),
    .mem_addr_not_aligned (mem_addr_not_aligned),
    .busy                 (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    RAM_OpCode = op;
    MAR_in     = a;
    MDR_in     = d;
    RAM_enable = 1'b1;
  endtask

  // Returns the index of the edge after which MFC was first seen high,
  // counting the next edge as 0; -1 if it never rose.
  task automatic wait_mfc(output int n);
    n = -1;
    for (int e = 0; e < 100; e++) begin
      @(posedge Clk); #1;
      if (MFC === 1'b1) begin
        n = e;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat);
    issue(op, a, d);
    wait_mfc(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic release_req(input string tag);
    RAM_enable = 1'b0;
    @(posedge Clk); #1;
    check({tag, "_mfc_low"}, 32'(MFC), 32'd0);
    check({tag, "_flag_low"}, 32'(mem_addr_not_aligned), 32'd0);
  endtask

  task automatic mem_check(input string tag, input int a, input logic [7:0] exp);
    check(tag, 32'(dut.ram.Mem[a]), 32'(exp));
  endtask

  initial begin
    Clr        = 1'b0;
    RAM_enable = 1'b0;
    RAM_OpCode = '0;
    MAR_in     = '0;
    MDR_in     = '0;
    #22;
    check("rst_dataout", RAM_DataOut, 32'h0);
    check("rst_mfc", 32'(MFC), 32'd0);
    check("rst_flag", 32'(mem_addr_not_aligned), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    Clr = 1'b1;
    @(posedge Clk); #1;

    // word store
    for (int i = 8; i < 12; i++) dut.ram.Mem[i] = 8'hFF;
    do_op("st8", OP_ST, 32'd8, 32'h12345678, 9);
    mem_check("st8_m8", 8, 8'h12);
    mem_check("st8_m9", 9, 8'h34);
    mem_check("st8_m10", 10, 8'h56);
    mem_check("st8_m11", 11, 8'h78);
    check("st8_dataout", RAM_DataOut, 32'h0);
    release_req("st8");

    // loads with extension
    dut.ram.Mem[8]  = 8'h80;
    dut.ram.Mem[9]  = 8'h01;
    dut.ram.Mem[10] = 8'h7F;
    dut.ram.Mem[11] = 8'hFF;
    do_op("ld8", OP_LD, 32'd8, 32'h0, 9);
    check("ld8_data", RAM_DataOut, 32'h80017FFF);
    release_req("ld8");
    do_op("ldsb8", OP_LDSB, 32'd8, 32'h0, 3);
    check("ldsb8_data", RAM_DataOut, 32'hFFFFFF80);
    release_req("ldsb8");
    do_op("ldub8", OP_LDUB, 32'd8, 32'h0, 3);
    check("ldub8_data", RAM_DataOut, 32'h00000080);
    release_req("ldub8");
    do_op("ldsh10", OP_LDSH, 32'd10, 32'h0, 5);
    check("ldsh10_data", RAM_DataOut, 32'h00007FFF);
    release_req("ldsh10");
    do_op("lduh8", OP_LDUH, 32'd8, 32'h0, 5);
    check("lduh8_data", RAM_DataOut, 32'h00008001);
    release_req("lduh8");

    // partial stores
    do_op("stb9", OP_STB, 32'd9, 32'hAABBCCDD, 3);
    mem_check("stb9_m8", 8, 8'h80);
    mem_check("stb9_m9", 9, 8'hDD);
    mem_check("stb9_m10", 10, 8'h7F);
    mem_check("stb9_m11", 11, 8'hFF);
    check("stb9_dataout", RAM_DataOut, 32'h00008001);
    release_req("stb9");
    do_op("sth10", OP_STH, 32'd10, 32'h00001234, 5);
    mem_check("sth10_m9", 9, 8'hDD);
    mem_check("sth10_m10", 10, 8'h12);
    mem_check("sth10_m11", 11, 8'h34);
    release_req("sth10");

    // misaligned requests
    do_op("ld9_mis", OP_LD, 32'd9, 32'h0, 1);
    check("ld9_mis_flag", 32'(mem_addr_not_aligned), 32'd1);
    check("ld9_mis_dataout", RAM_DataOut, 32'h00008001);
    mem_check("ld9_mis_m9", 9, 8'hDD);
    release_req("ld9_mis");
    dut.ram.Mem[7] = 8'h5A;
    do_op("sth7_mis", OP_STH, 32'd7, 32'h0000BEEF, 1);
    check("sth7_mis_flag", 32'(mem_addr_not_aligned), 32'd1);
    mem_check("sth7_mis_m7", 7, 8'h5A);
    mem_check("sth7_mis_m8", 8, 8'h80);
    release_req("sth7_mis");

    // high address bits ignored
    do_op("ldub_wrap", OP_LDUB, 32'h00000208, 32'h0, 3);
    check("ldub_wrap_data", RAM_DataOut, 32'h00000080);
    release_req("ldub_wrap");

    // enable held after MFC: no second access, inputs ignored
    dut.ram.Mem[12] = 8'h00;
    dut.ram.Mem[13] = 8'h00;
    do_op("hold", OP_STB, 32'd12, 32'h00000011, 3);
    MAR_in = 32'd13;
    MDR_in = 32'h00000022;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("hold_mfc", 32'(MFC), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
    end
    mem_check("hold_m12", 12, 8'h11);
    mem_check("hold_m13", 13, 8'h00);
    release_req("hold");

    // undefined opcode
    do_op("undef", 6'b111111, 32'd9, 32'hFFFFFFFF, 1);
    check("undef_data", RAM_DataOut, 32'h0);
    check("undef_flag", 32'(mem_addr_not_aligned), 32'd0);
    release_req("undef");

    // enable dropped mid-ACCESS
    issue(OP_ST, 32'd16, 32'hCAFEBABE);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
    end
    check("drop_busy", 32'(busy), 32'd1);
    RAM_enable = 1'b0;
    wait_mfc(lat);
    check("drop_latency", 32'(lat), 32'd6);
    @(posedge Clk); #1;
    check("drop_pulse", 32'(MFC), 32'd0);
    check("drop_state", 32'(dut.state), 32'(IDLE));
    mem_check("drop_m16", 16, 8'hCA);
    mem_check("drop_m17", 17, 8'hFE);
    mem_check("drop_m18", 18, 8'hBA);
    mem_check("drop_m19", 19, 8'hBE);

    // asynchronous reset after two bytes of a word store
    for (int i = 20; i < 24; i++) dut.ram.Mem[i] = 8'h00;
    issue(OP_ST, 32'd20, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
    end
    #2;
    Clr = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_mfc", 32'(MFC), 32'd0);
    check("rst_mid_dataout", RAM_DataOut, 32'h0);
    check("rst_mid_state", 32'(dut.state), 32'(IDLE));
    mem_check("rst_mid_m20", 20, 8'hDE);
    mem_check("rst_mid_m21", 21, 8'hAD);
    mem_check("rst_mid_m22", 22, 8'h00);
    mem_check("rst_mid_m23", 23, 8'h00);
    RAM_enable = 1'b0;
    #2;
    Clr = 1'b1;
    @(posedge Clk); #1;
    do_op("ld20", OP_LD, 32'd20, 32'h0, 9);
    check("ld20_data", RAM_DataOut, 32'hDEAD0000);
    release_req("ld20");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
